// File: rtl/aes_pkg.sv
// Shared AES definitions.
// Holds the state and byte typedefs, the FIPS-197 forward S-box table and
// a helper that maps a state byte index to its bit position.
// No ports (package).
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [7:0]   aes_byte_t;

   // Forward S-box, row n holds S(n0)..S(nf).
   localparam aes_byte_t SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Byte i of the state occupies bits [127-8i : 120-8i]; returns the LSB position.
   function automatic int unsigned byte_lsb(input int unsigned idx);
      return 120 - 8 * idx;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
// Ports:
//   i_byte  8-bit input byte
//   o_byte  8-bit substituted byte
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_subbytes.sv
// AES SubBytes stage with optional ShiftRows, one-cycle registered latency.
// Build option: define AES_SUBBYTES_SHIFTROWS_EN to append ShiftRows after
// SubBytes; otherwise the output is SubBytes only.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   state_in is valid this cycle
//   state_in   128-bit AES state, byte 0 in bits [127:120]
//   out_valid  state_out holds a fresh result
//   state_out  128-bit transformed state, registered
module aes_subbytes
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [127:0] state_in,
   output logic         out_valid,
   output logic [127:0] state_out
);

   aes_state_t w_sub;
   aes_state_t w_next;
   aes_state_t r_state;
   logic       r_valid;

   for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte (state_in[byte_lsb(gi) +: 8]),
         .o_byte (w_sub[byte_lsb(gi) +: 8])
      );
   end

`ifdef AES_SUBBYTES_SHIFTROWS_EN
   // Byte (r,c) sits at index r+4c; row r rotates left by r columns.
   for (genvar gr = 0; gr < 4; gr++) begin : g_row
      for (genvar gc = 0; gc < 4; gc++) begin : g_col
         assign w_next[byte_lsb(gr + 4 * gc) +: 8] =
            w_sub[byte_lsb(gr + 4 * ((gc + gr) % 4)) +: 8];
      end
   end
`else
   assign w_next = w_sub;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_state <= '0;
      end else begin
         r_valid <= in_valid;
         // Idle cycles keep the last result visible.
         if (in_valid) begin
            r_state <= w_next;
         end
      end
   end

   assign out_valid = r_valid;
   assign state_out = r_state;

endmodule

// File: tb/tb_aes_subbytes.sv
// Self-checking bench for aes_subbytes: directed vectors with hand-computed
// results plus an exhaustive byte sweep against a GF(2^8) reference model.
// Honours AES_SUBBYTES_SHIFTROWS_EN the same way as the design.
module tb_aes_subbytes;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic [127:0] state_in;
   logic         out_valid;
   logic [127:0] state_out;

   int unsigned n_checks;
   int unsigned n_pass;

   logic [7:0]   ref_sbox [256];

   localparam logic [127:0] FipsIn    = 128'h00102030405060708090a0b0c0d0e0f0;
`ifdef AES_SUBBYTES_SHIFTROWS_EN
   localparam logic [127:0] FipsOut   = 128'h6353e08c0960e104cd70b751bacad0e7;
`else
   localparam logic [127:0] FipsOut   = 128'h63cab7040953d051cd60e0e7ba70e18c;
`endif
   localparam logic [127:0] ZeroOut   = {16{8'h63}};
   localparam logic [127:0] OnesOut   = {16{8'h16}};

   aes_subbytes dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .state_in  (state_in),
      .out_valid (out_valid),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S(x) = affine(x^254), with 0 mapping to inverse 0.
   function automatic logic [7:0] sbox_model(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      if (a == 8'h00) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] state_model(input logic [127:0] s);
      logic [7:0]   sub [16];
      logic [7:0]   outb [16];
      logic [127:0] res;
      for (int i = 0; i < 16; i++) sub[i] = ref_sbox[s[127 - 8 * i -: 8]];
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
`ifdef AES_SUBBYTES_SHIFTROWS_EN
            outb[r + 4 * c] = sub[r + 4 * ((c + r) % 4)];
`else
            outb[r + 4 * c] = sub[r + 4 * c];
`endif
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = outb[i];
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] v;
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_model(i[7:0]);

      rst      = 1'b1;
      in_valid = 1'b0;
      state_in = '0;
      tick();
      tick();
      check("reset_valid", {127'd0, out_valid}, 128'd0);
      check("reset_state", state_out, 128'd0);

      // Accept on the first edge after reset drops.
      rst      = 1'b0;
      in_valid = 1'b1;
      state_in = FipsIn;
      tick();
      check("fips_valid", {127'd0, out_valid}, 128'd1);
      check("fips_state", state_out, FipsOut);

      // Back-to-back: zeros, FIPS, all-ff.
      state_in = '0;
      tick();
      check("b2b_zero_valid", {127'd0, out_valid}, 128'd1);
      check("b2b_zero_state", state_out, ZeroOut);
      state_in = FipsIn;
      tick();
      check("b2b_fips_valid", {127'd0, out_valid}, 128'd1);
      check("b2b_fips_state", state_out, FipsOut);
      state_in = '1;
      tick();
      check("b2b_ones_valid", {127'd0, out_valid}, 128'd1);
      check("b2b_ones_state", state_out, OnesOut);

      // Idle: output register holds while input wanders.
      in_valid = 1'b0;
      state_in = 128'hdeadbeef_01234567_89abcdef_55aa55aa;
      tick();
      check("idle_valid", {127'd0, out_valid}, 128'd0);
      check("idle_state", state_out, OnesOut);
      tick();
      check("idle2_state", state_out, OnesOut);

      // Reset wins over a valid input in the same cycle.
      rst      = 1'b1;
      in_valid = 1'b1;
      state_in = FipsIn;
      tick();
      check("rst_prio_valid", {127'd0, out_valid}, 128'd0);
      check("rst_prio_state", state_out, 128'd0);
      rst      = 1'b0;
      state_in = '1;
      tick();
      check("post_rst_valid", {127'd0, out_valid}, 128'd1);
      check("post_rst_state", state_out, OnesOut);

      // Exhaustive sweep of byte 0, other bytes varied so every position moves.
      for (int k = 0; k < 256; k++) begin
         v = '0;
         for (int b = 0; b < 16; b++) v[127 - 8 * b -: 8] = 8'(k + 17 * b);
         state_in = v;
         tick();
         check("sweep_valid", {127'd0, out_valid}, 128'd1);
         check("sweep_byte0", {120'd0, state_out[127:120]}, {120'd0, ref_sbox[k]});
         check("sweep_state", state_out, state_model(v));
      end

      in_valid = 1'b0;
      tick();
      check("end_valid", {127'd0, out_valid}, 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_subbytes.md
AES_SUBBYTES -- requirements
Module: aes_subbytes

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_in carries a state to transform this cycle.
- state_in  input  128  AES state.
- out_valid  output  1  state_out carries a transformed state.
- state_out  output  128  transformed AES state, registered.
REQ-003 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL use this state byte order:
- byte i = bits [127-8i : 120-8i], for i = 0..15.
- byte i sits at row r = i mod 4, column c = i div 4 (column-major, FIPS-197).
REQ-005 SubBytes SHALL replace each of the 16 bytes with the FIPS-197 forward S-box value.
- Reference points: S(00)=63, S(10)=ca, S(20)=b7, S(53)=ed, S(ff)=16.
REQ-006 ShiftRows (when compiled in) SHALL set out(r,c) = in(r,(c+r) mod 4), applied after SubBytes.
- Row 0 is unshifted; rows 1, 2 and 3 rotate left by 1, 2 and 3 bytes.
REQ-007 Latency SHALL be exactly one clock.
- A state presented with in_valid=1 at edge N appears on state_out with out_valid=1 after edge N.
REQ-008 There SHALL be no backpressure. Back-to-back in_valid=1 gives one output per cycle, with full throughput.
REQ-009 A cycle with in_valid=0 and rst=0 SHALL clear out_valid to 0 at the next edge; state_out holds its previous value.
REQ-010 The transform SHALL be purely per-state; no state is carried between inputs other than the output register.

Reset
REQ-011 With rst=1 at a clock edge, out_valid SHALL become 0 and state_out SHALL become 128'h0.
REQ-012 rst SHALL take priority over in_valid in the same cycle, so the input of that cycle is dropped.
REQ-013 In the first edge after rst deasserts, the block SHALL accept input normally.

Configuration
REQ-014 The macro AES_SUBBYTES_SHIFTROWS_EN SHALL control the ShiftRows stage.
- Defined: state_out = ShiftRows(SubBytes(state_in)).
- Undefined: state_out = SubBytes(state_in), with the ShiftRows logic absent.
- Latency, ports and reset behaviour SHALL be identical in both builds.

Structure
REQ-015 A shared package aes_pkg SHALL hold the following; block-local constants are not allowed:
- typedefs: aes_state_t (128-bit) and aes_byte_t (8-bit);
- the 256-entry forward S-box constant table;
- a byte-index helper function.
REQ-016 One sub-module aes_sbox SHALL be used: 8-bit in, 8-bit out, combinational table lookup, instantiated 16 times.
REQ-017 The ShiftRows stage SHALL be pure wiring inside aes_subbytes, with no registers.

Verification
REQ-018 Macro off, FIPS vector:
- Stimulus: in_valid=1, state_in=00102030405060708090a0b0c0d0e0f0.
- Response, next cycle: out_valid=1, state_out=63cab7040953d051cd60e0e7ba70e18c.
REQ-019 Macro on, same vector:
- Response, next cycle: state_out=6353e08c0960e104cd70b751bacad0e7.
REQ-020 Uniform states, either build:
- All-zero input -> 63 repeated 16 times.
- All-ff input -> 16 repeated 16 times.
REQ-021 Back-to-back and idle:
- Inputs: zeros, then the FIPS vector, then ff..ff on consecutive cycles.
- Outputs: the three results on consecutive cycles.
- Next cycle with in_valid=0: out_valid=0 and state_out keeps 1616..16.
REQ-022 Reset mid-stream:
- Stimulus: rst=1 together with in_valid=1 and the FIPS vector.
- Response, next edge: out_valid=0, state_out=0.
- The first input after rst drops SHALL produce the correct result one cycle later.
REQ-023 Exhaustive S-box check: all 256 byte values in byte position 0 SHALL match the FIPS-197 table, in both builds.
